alu8_seq_core: RTL and testbench

ALU8_SEQ_CORE -- requirements
Module: alu8_seq_core

---
 rtl/alu8_seq_pkg.sv | 31 +++
 rtl/alu8_seq_mul.sv | 60 ++++++
 rtl/alu8_seq_core.sv | 187 ++++++++++++++++++
 tb/tb_alu8_seq_core.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu8_seq_pkg.sv
// alu8_seq_pkg
// Shared definitions for the sequential ALU core and its multiplier:
//   op_t     - 3-bit opcode encoding presented on the core's op port
//   state_t  - control states of the core (IDLE, BUSY, DONE)
//   FLAG_*   - bit positions inside the 4-bit flags word {err, ovf, carry, zero}
package alu8_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_ERR   = 3;
    localparam int FLAG_W     = 4;

endpackage

// File: rtl/alu8_seq_mul.sv
// alu8_seq_mul
// Iterative unsigned shift-add multiplier, one partial product per clock.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   start         - load operands a/b and begin MUL_CYC iterations
//   a, b          - DATA_W-bit unsigned operands (sampled on start)
//   done          - high during the cycle whose edge completes the last iteration
//   product       - 2*DATA_W-bit product, valid while done is high
module alu8_seq_mul #(
    parameter int DATA_W  = 8,
    parameter int MUL_CYC = DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    localparam int CNT_W = $clog2(MUL_CYC + 1);

    logic [2*DATA_W-1:0] mcand_reg;
    logic [DATA_W-1:0]   mplier_reg;
    logic [2*DATA_W-1:0] acc_reg;
    logic [CNT_W-1:0]    cnt_reg;

    logic                busy;
    logic [2*DATA_W-1:0] acc_next;

    assign busy     = (cnt_reg != '0);
    assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

    // done/product are combinational on the final iteration so the core can
    // capture the product on the same edge that retires the last step; this
    // keeps the total latency at exactly MUL_CYC+1 edges after acceptance.
    assign done    = (cnt_reg == CNT_W'(1));
    assign product = acc_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
        end else if (start) begin
            mcand_reg  <= {{DATA_W{1'b0}}, a};
            mplier_reg <= b;
            acc_reg    <= '0;
            cnt_reg    <= CNT_W'(MUL_CYC);
        end else if (busy) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu8_seq_core.sv
// alu8_seq_core
// Sequential ALU with valid/ready handshakes on both sides.
// Single-cycle ops (ADD/SUB/AND/OR/XOR/SHL/SHR) go IDLE->DONE; MUL runs an
// iterative shift-add multiplier through BUSY. The result is held in DONE until
// the consumer takes it.
// Build option: define ALU8_SEQ_MUL_EN to include the multiplier and BUSY
// state; without it, op 111 is an illegal op (res=0, err=1, zero=1, 1 cycle).
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - command handshake (in_ready only in IDLE)
//   op, a, b            - opcode and DATA_W-bit operands
//   out_valid/out_ready - result handshake
//   res                 - 2*DATA_W-bit result (upper half zero for non-MUL)
//   flags               - {err, ovf, carry, zero}
module alu8_seq_core #(
    parameter int DATA_W  = 8,
    parameter int MUL_CYC = DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATA_W-1:0]   res,
    output logic [3:0]            flags
);

    import alu8_seq_pkg::*;

    localparam int MSB = DATA_W - 1;

    state_t              state_reg;
    logic                in_ready_reg;
    logic                out_valid_reg;
    logic [2*DATA_W-1:0] res_reg;
    logic [3:0]          flags_reg;

    logic                accept;
    logic [2:0]          sh_amt;
    logic [DATA_W:0]     sum_ext;
    logic [DATA_W:0]     diff_ext;
    logic [DATA_W:0]     shl_ext;
    logic [DATA_W:0]     shr_ext;
    logic [DATA_W-1:0]   alu_low;
    logic [2*DATA_W-1:0] alu_res;
    logic [3:0]          alu_flags;

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign res       = res_reg;
    assign flags     = flags_reg;

    assign accept = in_valid && in_ready_reg;

    // One extra bit on each side of the shifters catches the last bit shifted
    // out; a zero shift leaves that bit at its zero fill, giving carry=0.
    assign sh_amt   = b[2:0];
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};
    assign shl_ext  = {1'b0, a} << sh_amt;
    assign shr_ext  = {a, 1'b0} >> sh_amt;

    // Single-cycle datapath, evaluated straight from the port operands and
    // captured into res/flags on the accepting edge, so later input changes
    // cannot disturb the result.
    always_comb begin
        alu_low   = '0;
        alu_flags = '0;
        case (op_t'(op))
            OP_ADD: begin
                alu_low              = sum_ext[MSB:0];
                alu_flags[FLAG_CARRY] = sum_ext[DATA_W];
                alu_flags[FLAG_OVF]   = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
            end
            OP_SUB: begin
                alu_low              = diff_ext[MSB:0];
                alu_flags[FLAG_CARRY] = diff_ext[DATA_W];  // borrow
                alu_flags[FLAG_OVF]   = (a[MSB] != b[MSB]) && (diff_ext[MSB] != a[MSB]);
            end
            OP_AND: alu_low = a & b;
            OP_OR:  alu_low = a | b;
            OP_XOR: alu_low = a ^ b;
            OP_SHL: begin
                alu_low              = shl_ext[MSB:0];
                alu_flags[FLAG_CARRY] = shl_ext[DATA_W];
            end
            OP_SHR: begin
                alu_low              = shr_ext[DATA_W:1];
                alu_flags[FLAG_CARRY] = shr_ext[0];
            end
            OP_MUL: begin
`ifndef ALU8_SEQ_MUL_EN
                alu_flags[FLAG_ERR] = 1'b1;
`endif
            end
        endcase
        alu_res              = {{DATA_W{1'b0}}, alu_low};
        alu_flags[FLAG_ZERO] = (alu_res == '0);
    end

`ifdef ALU8_SEQ_MUL_EN
    logic                mul_start;
    logic                mul_done;
    logic [2*DATA_W-1:0] mul_product;
    logic [3:0]          mul_flags;

    assign mul_start = accept && (op == OP_MUL);

    always_comb begin
        mul_flags            = '0;
        mul_flags[FLAG_OVF]  = |mul_product[2*DATA_W-1:DATA_W];
        mul_flags[FLAG_ZERO] = (mul_product == '0);
    end

    alu8_seq_mul #(
        .DATA_W  (DATA_W),
        .MUL_CYC (MUL_CYC)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );
`endif

    // in_ready is a registered copy of "state is IDLE". It drops on the
    // accepting edge and only rises on the DONE->IDLE edge, so a command can
    // never be taken in the same cycle the previous result is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            res_reg       <= '0;
            flags_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        in_ready_reg <= 1'b0;
`ifdef ALU8_SEQ_MUL_EN
                        if (op == OP_MUL)
                            state_reg <= ST_BUSY;
                        else
`endif
                        begin
                            state_reg     <= ST_DONE;
                            out_valid_reg <= 1'b1;
                            res_reg       <= alu_res;
                            flags_reg     <= alu_flags;
                        end
                    end
                end
`ifdef ALU8_SEQ_MUL_EN
                ST_BUSY: begin
                    if (mul_done) begin
                        state_reg     <= ST_DONE;
                        out_valid_reg <= 1'b1;
                        res_reg       <= mul_product;
                        flags_reg     <= mul_flags;
                    end
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        state_reg     <= ST_IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu8_seq_core.sv
// tb_alu8_seq_core
// Self-checking bench for alu8_seq_core (DATA_W=8, MUL_CYC=8). Expected values
// come from an arithmetic reference model of the opcode rules. Honors the
// ALU8_SEQ_MUL_EN build option for the MUL-specific steps.
module tb_alu8_seq_core;

    localparam int DATA_W = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] res;
    logic [3:0]  flags;

    int n_cmp  = 0;
    int n_bad  = 0;
    int txn_id = 0;

    always #5 clk = ~clk;

    alu8_seq_core #(
        .DATA_W  (8),
        .MUL_CYC (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .flags     (flags)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns {err, ovf, carry, zero, res[15:0]} from plain integer arithmetic.
    function automatic logic [19:0] model(input logic [2:0] m_op, input int ua, input int ub);
        int r;
        int sa;
        int sb;
        int sh;
        bit c;
        bit v;
        bit e;
        r  = 0;
        c  = 1'b0;
        v  = 1'b0;
        e  = 1'b0;
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        sh = ub % 8;
        case (m_op)
            3'd0: begin
                r = ua + ub;
                c = (r > 255);
                r = r % 256;
                v = ((sa + sb) > 127) || ((sa + sb) < -128);
            end
            3'd1: begin
                c = (ua < ub);
                r = (ua - ub + 256) % 256;
                v = ((sa - sb) > 127) || ((sa - sb) < -128);
            end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: begin
                r = (ua << sh) % 256;
                c = (sh != 0) && (((ua >> (8 - sh)) & 1) == 1);
            end
            3'd6: begin
                r = ua >> sh;
                c = (sh != 0) && (((ua >> (sh - 1)) & 1) == 1);
            end
            default: begin
`ifdef ALU8_SEQ_MUL_EN
                r = ua * ub;
                v = (r > 255);
`else
                e = 1'b1;
                r = 0;
`endif
            end
        endcase
        return {e, v, c, (r == 0), 16'(r)};
    endfunction

    // Issues one command with out_ready low, measures latency, checks the
    // result, holds it for 'stall' cycles, then consumes it.
    task automatic run_txn(input logic [2:0] t_op, input logic [7:0] t_a, input logic [7:0] t_b,
                           input int stall);
        logic [19:0] exp;
        logic [15:0] held;
        int lat;
        int exp_lat;
        exp     = model(t_op, int'(t_a), int'(t_b));
        exp_lat = 1;
`ifdef ALU8_SEQ_MUL_EN
        if (t_op == 3'b111) exp_lat = DATA_W + 1;
`endif
        out_ready = 1'b0;
        op        = t_op;
        a         = t_a;
        b         = t_b;
        in_valid  = 1'b1;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        op       = 3'($urandom);
        a        = 8'($urandom);
        b        = 8'($urandom);
        lat      = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            check("in_ready_busy", 32'(in_ready), 32'd0);
            step();
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("res", 32'(res), 32'(exp[15:0]));
        check("flags", 32'(flags), 32'(exp[19:16]));
        check("in_ready_done", 32'(in_ready), 32'd0);
        held = res;
        for (int i = 0; i < stall; i++) begin
            step();
            check("res_hold", 32'(res), 32'(held));
            check("out_valid_hold", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("out_valid_clear", 32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
        $display("txn %0d: op=%0d a=%02h b=%02h res=%04h flags=%04b lat=%0d",
                 txn_id, t_op, t_a, t_b, held, exp[19:16], lat);
        txn_id++;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 3'd0;
        a         = 8'd0;
        b         = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_res", 32'(res), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);

        // ADD wrap: carry and zero, no overflow
        run_txn(3'b000, 8'hFF, 8'h01, 0);
        // SUB signed overflow, no borrow
        run_txn(3'b001, 8'h80, 8'h01, 1);
`ifdef ALU8_SEQ_MUL_EN
        run_txn(3'b111, 8'hFF, 8'hFF, 0);
`else
        run_txn(3'b111, 8'h3C, 8'h11, 0);
`endif
        // shift boundaries: amount 7, amount 0 (b=8 uses only b[2:0])
        run_txn(3'b101, 8'h81, 8'h07, 0);
        run_txn(3'b101, 8'hC3, 8'h01, 0);
        run_txn(3'b110, 8'h81, 8'h08, 0);
        run_txn(3'b110, 8'h81, 8'h01, 0);

        // XOR held under back-pressure, then next command on the second edge
        op = 3'b100; a = 8'hA5; b = 8'h5A; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check("xor_valid", 32'(out_valid), 32'd1);
        check("xor_res", 32'(res), 32'h00FF);
        for (int i = 0; i < 5; i++) begin
            step();
            check("xor_res_stall", 32'(res), 32'h00FF);
            check("xor_in_ready_stall", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1; op = 3'b000; a = 8'h12; b = 8'h34; in_valid = 1'b1;
        step();
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_no_result", 32'(out_valid), 32'd0);
        step();
        in_valid = 1'b0;
        check("second_cmd_valid", 32'(out_valid), 32'd1);
        check("second_cmd_res", 32'(res), 32'h0046);
        step();
        out_ready = 1'b0;
        check("second_cmd_taken", 32'(out_valid), 32'd0);
        $display("txn %0d: xor back-pressure then add a=12 b=34", txn_id);
        txn_id++;

        // Reset while a result is pending must discard it
`ifdef ALU8_SEQ_MUL_EN
        op = 3'b111; a = 8'h9D; b = 8'h47; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
`else
        op = 3'b011; a = 8'h9D; b = 8'h47; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
`endif
        rst = 1'b1;
        #2;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_res", 32'(res), 32'd0);
        check("midrst_flags", 32'(flags), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            check("post_rst_no_valid", 32'(out_valid), 32'd0);
        end
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        $display("txn %0d: reset during pending command", txn_id);
        txn_id++;

        // Randomized commands against the reference model
        for (int i = 0; i < 40; i++) begin
            run_txn(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
